muldiv_iter: RTL

Iterative, parametrised RV32M/RV64M multiply-divide unit for the execute stage of the pipelined core. It replaces the fixed-width combinational multiplier and divider with one shared sequential datapath. The datapath carries a start/busy/done handshake that the hazard unit uses to stall F/D/E, and a kill input that the hazard unit uses to abort on flush. All eight M-extension operations are supported, including the architecturally defined divide-by-zero and signed-overflow results.

---
 rtl/muldiv_iter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on a shared hi/lo register pair, with start/busy/done/kill handshake.
module muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic              r_sa, r_sb;
    logic [XLEN-1:0]   r_mb, r_hi, r_lo, r_result;
    logic              r_busy, r_done;

    logic              w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
    logic [XLEN-1:0]   w_mag_a, w_mag_b;
    logic              w_bzero, w_ovf, w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN:0]     w_add, w_shift, w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

    always_comb begin
        w_sgn_a = 1'b0;
        w_sgn_b = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b110: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            3'b010:                          w_sgn_a = 1'b1;
            default: ;
        endcase
    end

    // Sign flags record actual negativity, so FIX only negates where needed
    assign w_neg_a = w_sgn_a & a[XLEN-1];
    assign w_neg_b = w_sgn_b & b[XLEN-1];
    assign w_mag_a = w_neg_a ? ('0 - a) : a;
    assign w_mag_b = w_neg_b ? ('0 - b) : b;

    assign w_bzero    = (b == '0);
    assign w_ovf      = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    assign w_fast     = op[2] & (w_bzero | w_ovf);
    assign w_fast_res = w_bzero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    // Multiply step: conditional add of |b| into hi, then shift {carry,hi,lo} right
    assign w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mb} : '0);
    // Divide step: remainder in hi, dividend shifting out of lo, quotient shifting in
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_mb};
    assign w_ge    = w_shift[XLEN] | ~w_diff[XLEN];

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = (r_sa ^ r_sb) ? ('0 - w_prod) : w_prod;
    assign w_quo    = (r_sa ^ r_sb) ? ('0 - r_lo) : r_lo;
    assign w_rem    = r_sa ? ('0 - r_hi) : r_hi;

    always_comb begin
        w_fix_res = w_rem;
        case (r_op)
            3'b000:                 w_fix_res = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_mb     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (kill) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_op  <= op;
                            r_sa  <= w_neg_a;
                            r_sb  <= w_neg_b;
                            r_mb  <= w_mag_b;
                            r_hi  <= '0;
                            r_lo  <= w_mag_a;
                            r_cnt <= CW'(XLEN);
                            if (w_fast) begin
                                r_result <= w_fast_res;
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                                r_busy   <= 1'b0;
                            end else begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b1;
                            end
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (r_op[2]) begin
                            r_hi <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], w_ge};
                        end else begin
                            r_hi <= w_add[XLEN:1];
                            r_lo <= {w_add[0], r_lo[XLEN-1:1]};
                        end
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1))
                            r_state <= S_FIX;
                    end
                    S_FIX: begin
                        r_result <= w_fix_res;
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
